// File: rtl/trng_pkg.sv
// Shared helpers for the TRNG conditioner: counter-width function and the
// von Neumann pair-state encoding.
package trng_pkg;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_e;

endpackage

// File: rtl/trng_conditioner_if.sv
// Valid/ready word port between the conditioner and its consumer.
interface trng_conditioner_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/trng_rct_health.sv
// Repetition-count health test on the raw sample stream with a sticky fail flag.
module trng_rct_health
  import trng_pkg::*;
#(
  parameter int RCT_LIMIT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic strobe_i,
  input  logic raw_i,
  input  logic clr_fail_i,
  output logic fail_o
);

  localparam int RCT_W = cw(RCT_LIMIT + 1);
  localparam logic [RCT_W-1:0] LIMIT = RCT_W'(RCT_LIMIT);

  logic [RCT_W-1:0] run_q, run_d, run_nxt;
  logic             prev_q, prev_d;
  logic             fail_q, fail_d;
  logic             trip;

  always_comb begin
    // Saturate at the limit so a long run never wraps back below it.
    run_nxt = RCT_W'(1);
    if (raw_i == prev_q) run_nxt = (run_q == LIMIT) ? run_q : run_q + 1'b1;
    trip   = strobe_i && (run_nxt == LIMIT);
    prev_d = strobe_i ? raw_i : prev_q;
    run_d  = run_q;
    if (!en_i || clr_fail_i) run_d = '0;
    else if (strobe_i)       run_d = run_nxt;
    fail_d = trip | (fail_q & ~clr_fail_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
      fail_q <= fail_d;
    end
  end

  assign fail_o = fail_q;

endmodule

// File: rtl/trng_conditioner.sv
// Ring-oscillator sampler: sync, channel XOR, decimation, optional von Neumann
// debias, health test and word packing onto a valid/ready port.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int N_RO        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DECIM       = 4,
  parameter int WORD_W      = 8,
  parameter int RCT_LIMIT   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [N_RO-1:0]     ro_raw,
  input  logic [N_RO-1:0]     ch_mask,
  input  logic                vn_en,
  input  logic                clr_fail,
  trng_conditioner_if.master  out_if,
  output logic                o_health_fail,
  output logic                o_overrun
);

  localparam int DEC_W    = cw(DECIM);
  localparam int BITCNT_W = cw(WORD_W);

  logic [N_RO-1:0]     sync_q [SYNC_STAGES];
  logic                raw, strobe;
  logic [DEC_W-1:0]    dec_q, dec_d;
  pair_e               pair_q, pair_d;
  logic                first_q, first_d;
  logic                bit_vld, bit_val;
  logic [WORD_W-1:0]   shreg_q, shreg_d, new_word;
  logic [BITCNT_W-1:0] cnt_q, cnt_d;
  logic                pk_full_q, pk_full_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                ovr_q, ovr_d;
  logic                gate, accept, out_free, ovr_set;

  assign raw    = ^(sync_q[SYNC_STAGES-1] & ch_mask);
  assign strobe = i_en && (dec_q == DEC_W'(DECIM - 1));

  trng_rct_health #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (i_en),
    .strobe_i   (strobe),
    .raw_i      (raw),
    .clr_fail_i (clr_fail),
    .fail_o     (o_health_fail)
  );

  // Decimation and debias: a pending first half implies von Neumann mode, so
  // vn_en only matters while the pair is empty.
  always_comb begin
    dec_d   = (!i_en || strobe) ? '0 : dec_q + 1'b1;
    pair_d  = pair_q;
    first_d = first_q;
    bit_vld = 1'b0;
    bit_val = raw;
    if (!i_en || o_health_fail) begin
      pair_d = PAIR_EMPTY;
    end else if (strobe) begin
      if (pair_q == PAIR_HALF) begin
        pair_d  = PAIR_EMPTY;
        bit_vld = (first_q != raw);
        bit_val = first_q;
      end else if (vn_en) begin
        pair_d  = PAIR_HALF;
        first_d = raw;
      end else begin
        bit_vld = 1'b1;
      end
    end
  end

  // Packer and output register; a completed word waits in the packer while
  // the output register is occupied and not being drained.
  always_comb begin
    gate        = !i_en || o_health_fail;
    accept      = out_valid_q & out_if.i_ready;
    out_free    = !out_valid_q | accept;
    new_word    = {shreg_q[WORD_W-2:0], bit_val};
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pk_full_d   = pk_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~accept;
    ovr_set     = 1'b0;
    if (gate) begin
      shreg_d   = '0;
      cnt_d     = '0;
      pk_full_d = 1'b0;
    end else if (pk_full_q) begin
      ovr_set = bit_vld;
      if (out_free) begin
        out_data_d  = shreg_q;
        out_valid_d = 1'b1;
        pk_full_d   = 1'b0;
        shreg_d     = '0;
      end
    end else if (bit_vld) begin
      shreg_d = new_word;
      if (cnt_q == BITCNT_W'(WORD_W - 1)) begin
        cnt_d = '0;
        if (out_free) begin
          out_data_d  = new_word;
          out_valid_d = 1'b1;
        end else begin
          pk_full_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    ovr_d = ovr_set | (ovr_q & ~clr_fail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dec_q       <= '0;
      pair_q      <= PAIR_EMPTY;
      first_q     <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pk_full_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q[0] <= ro_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dec_q       <= dec_d;
      pair_q      <= pair_d;
      first_q     <= first_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pk_full_q   <= pk_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_if.o_data  = out_data_q;
  assign out_if.o_valid = out_valid_q;
  assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner with hand-computed words (default parameters).
module tb_trng_conditioner;

  logic       clk = 1'b0;
  logic       rst_n, i_en, vn_en, clr_fail;
  logic [3:0] ro_raw, ch_mask;
  logic       o_health_fail, o_overrun;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  trng_conditioner_if #(.WORD_W(8)) bus ();

  trng_conditioner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .ro_raw        (ro_raw),
    .ch_mask       (ch_mask),
    .vn_en         (vn_en),
    .clr_fail      (clr_fail),
    .out_if        (bus),
    .o_health_fail (o_health_fail),
    .o_overrun     (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Each bit is held for one decimation period, starting at the negedge after
  // the previous strobe; MSB of v goes first. Returns on the negedge after the
  // strobe that sampled the last bit.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_en   = 1'b1;
      ro_raw = {4{v[i]}};
      repeat (4) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr_fail = 1'b1;
    @(negedge clk);
    clr_fail = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_en = 1'b0; vn_en = 1'b0; clr_fail = 1'b0;
    ro_raw = '0; ch_mask = 4'b0001; bus.i_ready = 1'b0;
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_data", {24'd0, bus.o_data}, 32'd0);
    check("rst_fail", {31'd0, o_health_fail}, 32'd0);
    check("rst_ovr", {31'd0, o_overrun}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Disabled: toggling inputs must not produce anything.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ro_raw = ~ro_raw;
    end
    check("idle_valid", {31'd0, bus.o_valid}, 32'd0);

    // Plain sampling: 1,0,1,1,0,0,1,0 -> 8'hB2
    i_en = 1'b0; @(negedge clk);
    send_bits(32'h59, 7);
    check("b2_early_valid", {31'd0, bus.o_valid}, 32'd0);
    send_bits(32'h0, 1);
    check("b2_valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2_data", {24'd0, bus.o_data}, 32'hB2);
    i_en = 1'b0;
    repeat (10) @(negedge clk);
    check("b2_hold_valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2_hold_data", {24'd0, bus.o_data}, 32'hB2);
    bus.i_ready = 1'b1; @(negedge clk); bus.i_ready = 1'b0;
    check("b2_drained", {31'd0, bus.o_valid}, 32'd0);

    // Debias: pairs 01,10,11,00,10,10,01,01,10,01 give 0,1,1,1,0,0,1,0 -> 8'h72
    vn_en = 1'b1;
    send_bits(32'h1B296, 18);
    check("vn_early_valid", {31'd0, bus.o_valid}, 32'd0);
    send_bits(32'h1, 2);
    check("vn_valid", {31'd0, bus.o_valid}, 32'd1);
    check("vn_data", {24'd0, bus.o_data}, 32'h72);
    i_en = 1'b0;
    bus.i_ready = 1'b1; @(negedge clk); bus.i_ready = 1'b0;
    check("vn_drained", {31'd0, bus.o_valid}, 32'd0);

    // Health: masked-off channels give a constant raw stream.
    ch_mask = 4'b0000;
    i_en = 1'b1;
    repeat (124) @(posedge clk); @(negedge clk);
    check("rct_31", {31'd0, o_health_fail}, 32'd0);
    repeat (4) @(posedge clk); @(negedge clk);
    check("rct_32", {31'd0, o_health_fail}, 32'd1);
    pulse_clr();
    check("rct_clr", {31'd0, o_health_fail}, 32'd0);
    repeat (123) @(posedge clk); @(negedge clk);
    check("rct_re31", {31'd0, o_health_fail}, 32'd0);
    repeat (4) @(posedge clk); @(negedge clk);
    check("rct_re32", {31'd0, o_health_fail}, 32'd1);
    check("rct_no_valid", {31'd0, bus.o_valid}, 32'd0);
    i_en = 1'b0;
    pulse_clr();
    check("rct_clr2", {31'd0, o_health_fail}, 32'd0);
    vn_en = 1'b0; ch_mask = 4'b0001;

    // Backpressure: 3C in output, A5 stalled in packer, further bits dropped.
    send_bits(32'h3C, 8);
    check("bp_w1_valid", {31'd0, bus.o_valid}, 32'd1);
    check("bp_w1_data", {24'd0, bus.o_data}, 32'h3C);
    send_bits(32'hA5, 8);
    check("bp_w2_held", {24'd0, bus.o_data}, 32'h3C);
    check("bp_no_ovr", {31'd0, o_overrun}, 32'd0);
    send_bits(32'h1, 1);
    check("bp_ovr", {31'd0, o_overrun}, 32'd1);
    send_bits(32'h7F, 7);
    bus.i_ready = 1'b1; @(negedge clk);
    check("bp_w2_valid", {31'd0, bus.o_valid}, 32'd1);
    check("bp_w2_data", {24'd0, bus.o_data}, 32'hA5);
    @(negedge clk); bus.i_ready = 1'b0;
    check("bp_empty", {31'd0, bus.o_valid}, 32'd0);
    check("bp_ovr_sticky", {31'd0, o_overrun}, 32'd1);
    i_en = 1'b0;
    pulse_clr();
    check("bp_ovr_clr", {31'd0, o_overrun}, 32'd0);

    // Enable drop after 5 bits discards them; the next word is 8'h5A only.
    send_bits(32'h1F, 5);
    i_en = 1'b0;
    repeat (3) @(negedge clk);
    send_bits(32'h2D, 7);
    check("en_early_valid", {31'd0, bus.o_valid}, 32'd0);
    send_bits(32'h0, 1);
    check("en_valid", {31'd0, bus.o_valid}, 32'd1);
    check("en_data", {24'd0, bus.o_data}, 32'h5A);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("arst_data", {24'd0, bus.o_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("arst_after", {31'd0, bus.o_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
